// File: rtl/logic_pod_cmd_tx.sv
// logic_pod_cmd_tx: frames pod register-write commands as 5-byte UART packets with CRC-8
module logic_pod_cmd_tx #(
  parameter int   CLKS_PER_BIT = 2170,
  parameter logic TX_INVERT    = 1'b0
) (
  input  logic        clk_250mhz,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        tx_serial,
  output logic        busy,
  output logic        frame_done
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  state_t state, state_next;
  logic [TW-1:0] bit_timer, bit_timer_next;
  logic [2:0] bit_idx, bit_idx_next, byte_idx, byte_idx_next;
  logic [7:0] addr, crc, cur_byte;
  logic [15:0] data;
  logic tick, accept, last_stop, line_next;
  function automatic logic [7:0] crc8(input logic [23:0] m);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 23; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ m[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
  assign tick      = bit_timer == T_LAST;
  assign accept    = cmd_valid && cmd_ready;
  assign last_stop = state == STOP && tick && byte_idx == 3'd4;
  assign crc       = crc8({addr, data});
  assign cur_byte  = byte_idx == 3'd0 ? 8'h55 : byte_idx == 3'd1 ? addr :
                     byte_idx == 3'd2 ? data[15:8] : byte_idx == 3'd3 ? data[7:0] : crc;
  // state, counters and captured command
  always_ff @(posedge clk_250mhz) begin
    if (rst) begin
      state     <= IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      addr      <= '0;
      data      <= '0;
    end else begin
      state     <= state_next;
      bit_timer <= bit_timer_next;
      bit_idx   <= bit_idx_next;
      byte_idx  <= byte_idx_next;
      if (accept) begin
        addr <= cmd_addr;
        data <= cmd_data;
      end
    end
  end
  // next state: every non-idle transition happens when the bit timer wraps
  always_comb begin
    state_next = state == IDLE ? (accept ? START : IDLE) :
                 !tick ? state :
                 state == START ? DATA :
                 state == DATA ? (bit_idx == 3'd7 ? STOP : DATA) :
                 (byte_idx == 3'd4 ? IDLE : START);
  end
  // next counter values and the line level the next state will drive
  always_comb begin
    bit_timer_next = (state == IDLE || tick) ? '0 : bit_timer + 1'b1;
    bit_idx_next   = (state == DATA && tick) ? bit_idx + 3'd1 : bit_idx;
    byte_idx_next  = (state == STOP && tick) ? (byte_idx == 3'd4 ? 3'd0 : byte_idx + 3'd1) : byte_idx;
    line_next      = state_next == START ? 1'b0 : state_next == DATA ? cur_byte[bit_idx_next] : 1'b1;
  end
  // registered outputs, so nothing reaches the pins combinationally
  always_ff @(posedge clk_250mhz) begin
    if (rst) begin
      tx_serial  <= 1'b1 ^ TX_INVERT;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_serial  <= line_next ^ TX_INVERT;
      cmd_ready  <= state_next == IDLE;
      busy       <= state_next != IDLE;
      frame_done <= last_stop;
    end
  end
endmodule

// File: tb/tb_logic_pod_cmd_tx.sv
// tb_logic_pod_cmd_tx: randomized frame checks against a bit-level reference of the packet
module tb_logic_pod_cmd_tx;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic cmd_ready, tx_serial, busy, frame_done;
  logic ready_i, tx_i, busy_i, done_i;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  logic_pod_cmd_tx #(.CLKS_PER_BIT(4), .TX_INVERT(1'b0)) dut (
    .clk_250mhz(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .tx_serial(tx_serial), .busy(busy), .frame_done(frame_done));
  logic_pod_cmd_tx #(.CLKS_PER_BIT(4), .TX_INVERT(1'b1)) dut_inv (
    .clk_250mhz(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_i),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .tx_serial(tx_i), .busy(busy_i), .frame_done(done_i));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] crc_ref(input logic [7:0] a, input logic [15:0] d);
    logic [31:0] v;
    v = {a, d, 8'h00};
    for (int i = 31; i >= 8; i--) if (v[i]) v = v ^ (32'h107 << (i - 8));
    return v[7:0];
  endfunction
  function automatic logic [49:0] frame_ref(input logic [7:0] a, input logic [15:0] d);
    logic [7:0] by [5];
    logic [49:0] f;
    by = '{8'h55, a, d[15:8], d[7:0], crc_ref(a, d)};
    for (int b = 0; b < 5; b++) begin
      f[b*10] = 1'b0;
      for (int j = 0; j < 8; j++) f[b*10+1+j] = by[b][j];
      f[b*10+9] = 1'b1;
    end
    return f;
  endfunction
  task automatic run_frame(input logic [7:0] a, input logic [15:0] d, input bit keep,
                           input logic [7:0] na, input logic [15:0] nd);
    logic [49:0] fb;
    fb = frame_ref(a, d);
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_data = d;
    chk("ready_before_accept", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = keep;
    cmd_addr = keep ? na : 8'($urandom);
    cmd_data = keep ? nd : 16'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 200; k++) begin
      chk("tx_bit", 32'(tx_serial), 32'(fb[k/4]));
      chk("tx_inv_bit", 32'(tx_i), 32'(!fb[k/4]));
      chk("done_early", 32'(frame_done), 32'd0);
      chk("busy_frame", 32'(busy), 32'd1);
      if (!keep) begin
        cmd_valid = 1'($urandom);
        cmd_addr = 8'($urandom);
        cmd_data = 16'($urandom);
      end
      step();
    end
    if (!keep) cmd_valid = 1'b0;
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("done_inv", 32'(done_i), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("ready_end", 32'(cmd_ready), 32'd1);
    chk("tx_idle_end", 32'(tx_serial), 32'd1);
    chk("tx_inv_idle_end", 32'(tx_i), 32'd0);
  endtask
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("gap_tx", 32'(tx_serial), 32'd1);
      chk("gap_done", 32'(frame_done), 32'd0);
      chk("gap_ready", 32'(cmd_ready), 32'd1);
    end
  endtask
  initial begin
    logic [7:0] a2;
    logic [15:0] d2;
    repeat (5) step();
    chk("rst_tx", 32'(tx_serial), 32'd1);
    chk("rst_tx_inv", 32'(tx_i), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    step();
    run_frame(8'h01, 16'h0000, 1'b0, 8'h00, 16'h0000);
    idle_gap(2);
    run_frame(8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);
    idle_gap(1);
    for (int r = 0; r < 5; r++) begin
      run_frame(8'($urandom), 16'($urandom), 1'b0, 8'h00, 16'h0000);
      idle_gap(1 + int'($urandom_range(0, 3)));
    end
    a2 = 8'($urandom);
    d2 = 16'($urandom);
    run_frame(8'($urandom), 16'($urandom), 1'b1, a2, d2);
    run_frame(a2, d2, 1'b0, 8'h00, 16'h0000);
    idle_gap(1);
    cmd_valid = 1'b1;
    cmd_addr = 8'($urandom);
    cmd_data = 16'($urandom);
    step();
    cmd_valid = 1'b0;
    repeat (95) step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_tx", 32'(tx_serial), 32'd1);
    chk("midrst_tx_inv", 32'(tx_i), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    idle_gap(210);
    run_frame(8'($urandom), 16'($urandom), 1'b0, 8'h00, 16'h0000);
    idle_gap(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
